// File: rtl/popcount_stats_pkg.sv
// Shared types and defaults for the popcount window statistics block.
// Holds the output buffer state enum and the WIDTH/WINDOW defaults.
package popcount_stats_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int WINDOW_DEF = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/stats_out_buf.sv
// One-entry result buffer with valid/ready handshake and overrun flag.
// Ports: clk_i, arst_n_i, clear_i, load_i, ready_i, sum/min/max in, sum/min/max out, val_o, overrun_o.
module stats_out_buf
  import popcount_stats_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int SUM_W = 10
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             ready_i,
  input  logic [SUM_W-1:0] sum_i,
  input  logic [CNT_W-1:0] min_i,
  input  logic [CNT_W-1:0] max_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic             val_o,
  output logic             overrun_o
);

  out_state_e state, next_state;
  logic       take;
  logic       drop;

  always_comb begin
    next_state = state;
    take       = 1'b0;
    drop       = 1'b0;
    unique case (state)
      EMPTY: begin
        if (load_i) begin
          take       = 1'b1;
          next_state = FULL;
        end
      end
      FULL: begin
        if (load_i && ready_i) begin
          take = 1'b1;
        end else if (load_i) begin
          drop = 1'b1;
        end else if (ready_i) begin
          next_state = EMPTY;
        end
      end
      default: next_state = EMPTY;
    endcase
    if (clear_i) begin
      next_state = EMPTY;
      take       = 1'b0;
      drop       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sum_o     <= '0;
      min_o     <= '0;
      max_o     <= '0;
      overrun_o <= 1'b0;
    end else if (clear_i) begin
      sum_o     <= '0;
      min_o     <= '0;
      max_o     <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (take) begin
        sum_o <= sum_i;
        min_o <= min_i;
        max_o <= max_i;
      end
      if (drop) begin
        overrun_o <= 1'b1;
      end
    end
  end

  assign val_o = (state == FULL);

endmodule

// File: rtl/popcount_window_stats.sv
// Per-window sum/min/max of popcount samples with a held, handshaked result.
// Ports: clk_i, arst_n_i, data_i, data_val_i, clear_i, stats_ready_i, sum_o, min_o, max_o, stats_val_o, overrun_o.
module popcount_window_stats
  import popcount_stats_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int WINDOW = WINDOW_DEF,
  localparam int CNT_W  = $clog2(WIDTH) + 1,
  localparam int SUM_W  = CNT_W + $clog2(WINDOW)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             data_val_i,
  input  logic             clear_i,
  input  logic             stats_ready_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic             stats_val_o,
  output logic             overrun_o
);

  localparam int IDX_W = $clog2(WINDOW);

  logic [IDX_W-1:0] cnt;
  logic [SUM_W-1:0] sum_acc;
  logic [CNT_W-1:0] min_acc;
  logic [CNT_W-1:0] max_acc;

  logic             accept;
  logic             first;
  logic             last;
  logic [SUM_W-1:0] sum_nxt;
  logic [CNT_W-1:0] min_nxt;
  logic [CNT_W-1:0] max_nxt;

  assign accept = data_val_i && !clear_i;
  assign first  = (cnt == '0);
  assign last   = accept && (cnt == IDX_W'(WINDOW - 1));

  // The first sample of a window seeds all three accumulators.
  always_comb begin
    sum_nxt = SUM_W'(data_i);
    min_nxt = data_i;
    max_nxt = data_i;
    if (!first) begin
      sum_nxt = sum_acc + SUM_W'(data_i);
      if (min_acc < data_i) min_nxt = min_acc;
      if (max_acc > data_i) max_nxt = max_acc;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt     <= '0;
      sum_acc <= '0;
      min_acc <= '0;
      max_acc <= '0;
    end else if (clear_i) begin
      cnt     <= '0;
      sum_acc <= '0;
      min_acc <= '0;
      max_acc <= '0;
    end else if (accept) begin
      cnt     <= last ? '0 : cnt + 1'b1;
      sum_acc <= sum_nxt;
      min_acc <= min_nxt;
      max_acc <= max_nxt;
    end
  end

  stats_out_buf #(
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_buf (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .clear_i   (clear_i),
    .load_i    (last),
    .ready_i   (stats_ready_i),
    .sum_i     (sum_nxt),
    .min_i     (min_nxt),
    .max_i     (max_nxt),
    .sum_o     (sum_o),
    .min_o     (min_o),
    .max_o     (max_o),
    .val_o     (stats_val_o),
    .overrun_o (overrun_o)
  );

endmodule

// File: tb/tb_popcount_window_stats.sv
// Scoreboard bench for popcount_window_stats (WIDTH=32, WINDOW=4).
// Driver feeds samples into a window model; monitor checks the held result.
module tb_popcount_window_stats;

  localparam int WIDTH  = 32;
  localparam int WINDOW = 4;
  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int SUM_W  = CNT_W + $clog2(WINDOW);

  typedef struct {
    int s;
    int mn;
    int mx;
  } res_t;

  logic             clk_i = 1'b0;
  logic             arst_n_i = 1'b0;
  logic [CNT_W-1:0] data_i = '0;
  logic             data_val_i = 1'b0;
  logic             clear_i = 1'b0;
  logic             stats_ready_i = 1'b0;
  logic [SUM_W-1:0] sum_o;
  logic [CNT_W-1:0] min_o;
  logic [CNT_W-1:0] max_o;
  logic             stats_val_o;
  logic             overrun_o;

  int checks = 0;
  int errors = 0;

  int   samples[$];
  res_t win_q[$];
  bit   comp_now = 0;
  bit   clr_now = 0;

  bit   held = 0;
  bit   ov = 0;
  bit   zero_exp = 1;
  res_t cur;
  int   delivered = 0;

  popcount_window_stats #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW)
  ) dut (
    .clk_i         (clk_i),
    .arst_n_i      (arst_n_i),
    .data_i        (data_i),
    .data_val_i    (data_val_i),
    .clear_i       (clear_i),
    .stats_ready_i (stats_ready_i),
    .sum_o         (sum_o),
    .min_o         (min_o),
    .max_o         (max_o),
    .stats_val_o   (stats_val_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic res_t window_stats(int q[$]);
    res_t r;
    r.s = 0;
    r.mn = q[0];
    r.mx = q[0];
    foreach (q[i]) begin
      r.s += q[i];
      if (q[i] < r.mn) r.mn = q[i];
      if (q[i] > r.mx) r.mx = q[i];
    end
    return r;
  endfunction

  task automatic drive(bit v, int d, bit c, bit r);
    @(negedge clk_i);
    #1;
    data_val_i    = v;
    data_i        = CNT_W'(d);
    clear_i       = c;
    stats_ready_i = r;
    clr_now       = c;
    comp_now      = 0;
    if (c) begin
      samples.delete();
    end else if (v) begin
      samples.push_back(d);
      if (samples.size() == WINDOW) begin
        win_q.push_back(window_stats(samples));
        samples.delete();
        comp_now = 1;
      end
    end
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++) drive(0, 0, 0, r);
  endtask

  task automatic win4(int a, int b, int c, int d, int gap, bit r);
    drive(1, a, 0, r); idle(gap, r);
    drive(1, b, 0, r); idle(gap, r);
    drive(1, c, 0, r); idle(gap, r);
    drive(1, d, 0, r);
  endtask

  task automatic async_reset();
    @(negedge clk_i);
    #2;
    arst_n_i   = 1'b0;
    data_val_i = 1'b0;
    clear_i    = 1'b0;
    comp_now   = 0;
    clr_now    = 0;
    samples.delete();
    win_q.delete();
    #1;
    check("rst_val", int'(stats_val_o), 0);
    check("rst_ovr", int'(overrun_o), 0);
    check("rst_sum", int'(sum_o), 0);
    check("rst_min", int'(min_o), 0);
    check("rst_max", int'(max_o), 0);
    @(negedge clk_i);
    #1;
    arst_n_i = 1'b1;
  endtask

  // Monitor: checks the output against the buffer model just before each
  // rising edge, then advances the model with the inputs about to be sampled.
  initial begin
    forever begin
      @(negedge clk_i);
      #3;
      if (!arst_n_i) begin
        held     = 0;
        ov       = 0;
        zero_exp = 1;
      end else begin
        check("val", int'(stats_val_o), int'(held));
        check("overrun", int'(overrun_o), int'(ov));
        if (held) begin
          check("sum", int'(sum_o), cur.s);
          check("min", int'(min_o), cur.mn);
          check("max", int'(max_o), cur.mx);
        end else if (zero_exp) begin
          check("sum_zero", int'(sum_o), 0);
          check("min_zero", int'(min_o), 0);
          check("max_zero", int'(max_o), 0);
        end
        if (clr_now) begin
          held     = 0;
          ov       = 0;
          zero_exp = 1;
        end else if (comp_now) begin
          res_t w;
          w = win_q.pop_front();
          if (held && stats_ready_i) delivered++;
          if (!held || stats_ready_i) begin
            cur      = w;
            held     = 1;
            zero_exp = 0;
          end else begin
            ov = 1;
          end
        end else if (held && stats_ready_i) begin
          held = 0;
          delivered++;
        end
      end
    end
  end

  initial begin
    int d0;
    idle(2, 0);
    @(negedge clk_i);
    #1;
    arst_n_i = 1'b1;
    idle(2, 1);

    // back-to-back samples, then spaced samples
    win4(3, 7, 0, 32, 0, 1);
    idle(3, 1);
    win4(3, 7, 0, 32, 2, 1);
    idle(3, 1);

    // overrun with ready low, then release
    win4(1, 1, 1, 1, 0, 0);
    win4(2, 2, 2, 2, 0, 0);
    idle(2, 0);
    idle(3, 1);

    // clear aborts partial window and discards its own sample
    drive(1, 9, 0, 1);
    drive(1, 9, 0, 1);
    drive(1, 30, 1, 1);
    win4(5, 5, 5, 5, 0, 1);
    idle(3, 1);

    // continuous windows with ready held
    win4(1, 2, 3, 4, 0, 1);
    win4(4, 4, 4, 4, 0, 1);
    idle(3, 1);

    // reset while FULL with a partial window in flight
    win4(1, 2, 3, 4, 0, 0);
    drive(1, 5, 0, 0);
    drive(1, 6, 0, 0);
    async_reset();
    win4(10, 20, 30, 40, 0, 1);
    idle(3, 1);

    // reset mid-window while EMPTY
    drive(1, 7, 0, 1);
    drive(1, 8, 0, 1);
    async_reset();
    win4(63, 0, 63, 1, 0, 1);
    idle(3, 1);

    // random traffic, including values above WIDTH
    for (int i = 0; i < 400; i++) begin
      d0 = $urandom_range(63, 0);
      drive($urandom_range(99, 0) < 70, d0,
            $urandom_range(99, 0) < 3,
            $urandom_range(99, 0) < 60);
    end
    idle(4, 1);
    check("windows_drained", win_q.size(), 0);
    check("some_delivered", int'(delivered > 10), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_window_stats.md
POPCOUNT_WINDOW_STATS -- requirements
Module: popcount_window_stats

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the bit width of the upstream popcount word (count range 0..WIDTH).
REQ-002 SHALL have parameter WINDOW, default 16, the samples per statistics window (power of two, >= 2).
REQ-003 SHALL have derived constants CNT_W = $clog2(WIDTH)+1 and SUM_W = CNT_W+$clog2(WINDOW).
REQ-004 SHALL have port clk_i  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port arst_n_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port data_i  input  CNT_W  the popcount sample from the upstream bit population counter.
REQ-007 SHALL have port data_val_i  input  1  data_i valid; a sample is accepted on every edge where it is high (no backpressure to upstream).
REQ-008 SHALL have port clear_i  input  1  synchronous abort: restart window, drop held result, clear overrun.
REQ-009 SHALL have port stats_ready_i  input  1  downstream accepts the held result.
REQ-010 SHALL have port sum_o  output  SUM_W  the sum of the window's samples.
REQ-011 SHALL have port min_o  output  CNT_W  the minimum sample in the window.
REQ-012 SHALL have port max_o  output  CNT_W  the maximum sample in the window.
REQ-013 SHALL have port stats_val_o  output  1  the result is held and valid.
REQ-014 SHALL have port overrun_o  output  1  sticky flag: a completed window was dropped.

Function
REQ-015 SHALL keep a sample counter 0..WINDOW-1 that increments per accepted sample and wraps to 0 on the WINDOW-th.
REQ-016 SHALL keep running sum, min and max; the first sample of a window initialises min and max, overriding their previous values.
REQ-017 SHALL, on acceptance of the WINDOW-th sample, form the results including that sample and load them into the output registers at that edge, so stats_val_o rises one cycle after the last sample is presented (latency 1).
REQ-018 SHALL start the accumulators fresh with the next accepted sample, so back-to-back windows need no idle cycle.
REQ-019 SHALL implement an output FSM with states EMPTY (stats_val_o=0) and FULL (stats_val_o=1).
REQ-020 SHALL, on window completion in EMPTY, load the results and go to FULL.
REQ-021 SHALL, in FULL, go to EMPTY on an edge with stats_ready_i=1 unless a window completes on the same edge.
REQ-022 SHALL, in FULL with stats_ready_i=1 and completion on the same edge, load the new results and stay FULL with no overrun.
REQ-023 SHALL, in FULL with stats_ready_i=0 and completion, hold the old results, drop the new results and set overrun_o.
REQ-024 SHALL keep sum_o, min_o and max_o stable throughout FULL until the handshake edge.
REQ-025 SHALL have clear_i take priority over data_val_i: a sample presented in the clear_i cycle is discarded, the counter and accumulators are zeroed, the FSM goes to EMPTY and overrun_o is set to 0.
REQ-026 SHALL ensure sum_o cannot overflow (SUM_W covers WINDOW*(2^CNT_W-1)); data_i values above WIDTH are accumulated unmodified.
REQ-027 SHALL have the outputs sum_o, min_o and max_o read 0 whenever the FSM is EMPTY after reset or clear_i.

Reset
REQ-028 SHALL, while arst_n_i=0, force asynchronously and immediately: sample counter=0, accumulators=0, FSM=EMPTY, sum_o=0, min_o=0, max_o=0, stats_val_o=0, overrun_o=0.
REQ-029 SHALL treat deassertion of arst_n_i as synchronous to clk_i, and SHALL treat a partial window interrupted by reset as lost.

Structure
REQ-030 SHALL place the output FSM state enum (EMPTY, FULL) in package popcount_stats_pkg.
REQ-031 SHALL place the default values of WIDTH and WINDOW in popcount_stats_pkg.
REQ-032 SHALL compute CNT_W and SUM_W as localparams inside the module from its parameters.
REQ-033 SHALL use one sub-module, stats_out_buf, which holds the FSM and the output registers, with load, ready and overrun behaviour; accumulation SHALL stay in the top module.

Verification (WIDTH=32, WINDOW=4)
REQ-034 SHALL cover: samples 3,7,0,32 on consecutive cycles with ready=1 -> next cycle sum_o=42, min_o=0, max_o=32, stats_val_o=1 for one cycle.
REQ-035 SHALL cover: the same samples with 2 idle cycles between each -> identical results, stats_val_o rising one cycle after the sample 32.
REQ-036 SHALL cover: ready=0 with windows {1,1,1,1} then {2,2,2,2} -> sum_o=4 held, overrun_o=1; raising ready then -> stats_val_o=0 next cycle, no sum_o=8 ever output.
REQ-037 SHALL cover: samples 9,9, then clear_i with sample 30 in the same cycle, then 5,5,5,5 -> sum_o=20, min_o=5, max_o=5.
REQ-038 SHALL cover: continuous windows {1..4},{4,4,4,4} with ready=1 -> stats_val_o stays 1 across the boundary, sum_o 10 then 16, overrun_o=0.
REQ-039 SHALL cover: arst_n_i pulled low mid-window and while FULL -> all outputs 0 without waiting for a clock edge; the next 4 samples form a complete fresh window.
